act_share_sched: RTL and testbench

//   Round-robin scheduler sharing one combinational activation unit (hard sigmoid) among
//   N_REQ requesters, e.g. the LSTM gate lanes of the recurrent stage.

---
 rtl/act_share_sched.sv | 115 +++++++++++
 tb/tb_act_share_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/act_share_sched.sv
// Round-robin scheduler that time-shares one combinational activation unit
// among N_REQ requesters and registers each result, with the winner's ID,
// into a single valid/ready output stage.
module act_share_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int N_REQ      = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [N_REQ-1:0]            in_valid,
  output logic [N_REQ-1:0]            in_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0]       act_x,
  input  logic [DATA_WIDTH-1:0]       act_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [ID_WIDTH-1:0]         out_id,
  output logic [15:0]                 done_cnt
);

  // Parameter sanity: the ID field must be able to name every requester.
  if (N_REQ < 2 || N_REQ > 8 || (1 << ID_WIDTH) < N_REQ) begin : g_bad_params
    $error("act_share_sched: illegal N_REQ/ID_WIDTH combination");
  end

  localparam logic [ID_WIDTH:0]   NREQ_W = (ID_WIDTH+1)'(N_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(N_REQ - 1);

  logic [DATA_WIDTH-1:0] lane_data [N_REQ];
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  can_accept;
  logic                  grant;

  // Unpack the flat operand bus into one word per requester.
  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    assign lane_data[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Stage can take a new result when empty or when its content leaves now.
  assign can_accept = ~out_valid | out_ready;
  assign grant      = can_accept & (|in_valid) & ~flush & ~rst;
  assign next_ptr   = (winner == LAST_ID) ? '0 : winner + 1'b1;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    logic [ID_WIDTH:0] cand;
    logic              found;
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && in_valid[cand[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_WIDTH-1:0];
      end
    end
  end

  // One-hot accept to the winner and operand steering to the shared unit.
  always_comb begin
    in_ready = '0;
    act_x    = '0;
    if (grant) begin
      in_ready[winner] = 1'b1;
      act_x            = lane_data[winner];
    end
  end

  // Output stage: load on grant, drain on consume, hold under backpressure.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops
    // update together from values sampled before the edge.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= act_y;
      out_id    <= winner;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances past the winner; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= next_ptr;
    end
  end

  // Count consumed results; flush clears, natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_act_share_sched.sv
// Directed bench for act_share_sched with a stub activation unit
// (act_y = act_x ^ 16'h00FF); lane k carries operand 16'h0100*(k+1).
module tb_act_share_sched;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [NR-1:0]   in_valid;
  logic [NR-1:0]   in_ready;
  logic [NR*DW-1:0] in_data;
  logic [DW-1:0]   act_x;
  logic [DW-1:0]   act_y;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic [15:0]     done_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign act_y = act_x ^ 16'h00FF;

  act_share_sched #(.DATA_WIDTH(DW), .N_REQ(NR), .ID_WIDTH(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .act_x    (act_x),
    .act_y    (act_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .done_cnt (done_cnt)
  );

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected stub result for lane k.
  function automatic logic [15:0] lane_res(input int k);
    logic [15:0] op;
    op = 16'h0100 * (k + 1);
    return op ^ 16'h00FF;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 4'hF;
    cyc(); cyc();
    total++;
    if (in_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_in_ready got=%b exp=%b", in_ready, 4'b0000);
    end
    total++;
    if ({out_valid, out_id, out_data, done_cnt} !== {1'b0, 2'd0, 16'h0000, 16'h0000}) begin
      bad++; $display("FAIL reset_state got v=%b id=%0d d=%h cnt=%h exp 0/0/0000/0000",
                      out_valid, out_id, out_data, done_cnt);
    end
    rst = 1'b0; in_valid = 4'h0;
  endtask

  task automatic test_round_robin();
    int id;
    in_valid = 4'hF; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0001) begin
      bad++; $display("FAIL rr_first_ready got=%b exp=%b", in_ready, 4'b0001);
    end
    for (int j = 0; j < 6; j++) begin
      cyc();
      id = j % 4;
      total++;
      if ({out_valid, out_id, out_data} !== {1'b1, 2'(id), lane_res(id)}) begin
        bad++; $display("FAIL rr_out[%0d] got v=%b id=%0d d=%h exp 1/%0d/%h",
                        j, out_valid, out_id, out_data, id, lane_res(id));
      end
      total++;
      if (in_ready !== 4'(1 << ((j + 1) % 4))) begin
        bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", j, in_ready, 4'(1 << ((j + 1) % 4)));
      end
    end
    total++;
    if (done_cnt !== 16'd5) begin
      bad++; $display("FAIL rr_done_cnt got=%0d exp=5", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 4'h0; out_ready = 1'b1;
    cyc();
    in_valid = 4'b0100; out_ready = 1'b0;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin
      bad++; $display("FAIL bp_accept got=%b exp=%b", in_ready, 4'b0100);
    end
    cyc();
    for (int j = 0; j < 3; j++) begin
      total++;
      if ({in_ready, out_valid, out_id, out_data} !== {4'b0000, 1'b1, 2'd2, 16'h03FF}) begin
        bad++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b id=%0d d=%h exp 0000/1/2/03ff",
                        j, in_ready, out_valid, out_id, out_data);
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin
      bad++; $display("FAIL bp_release got=%b exp=%b", in_ready, 4'b0100);
    end
    cyc();
    total++;
    if ({out_valid, out_id, out_data} !== {1'b1, 2'd2, 16'h03FF}) begin
      bad++; $display("FAIL bp_replace got v=%b id=%0d d=%h exp 1/2/03ff", out_valid, out_id, out_data);
    end
    in_valid = 4'h0;
    cyc();
    total++;
    if ({out_valid, done_cnt} !== {1'b0, 16'd8}) begin
      bad++; $display("FAIL bp_drain got v=%b cnt=%0d exp 0/8", out_valid, done_cnt);
    end
  endtask

  task automatic test_rr_pointer();
    in_valid = 4'b1001; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b1000) begin
      bad++; $display("FAIL ptr_lane3_first got=%b exp=%b", in_ready, 4'b1000);
    end
    cyc();
    total++;
    if ({out_id, out_data, in_ready} !== {2'd3, 16'h04FF, 4'b0001}) begin
      bad++; $display("FAIL ptr_lane3_out got id=%0d d=%h rdy=%b exp 3/04ff/0001", out_id, out_data, in_ready);
    end
    cyc();
    total++;
    if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 16'h01FF}) begin
      bad++; $display("FAIL ptr_lane0_out got v=%b id=%0d d=%h exp 1/0/01ff", out_valid, out_id, out_data);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0000) begin
      bad++; $display("FAIL flush_no_grant got=%b exp=%b", in_ready, 4'b0000);
    end
    cyc();
    total++;
    if ({out_valid, out_id, out_data, done_cnt} !== {1'b0, 2'd0, 16'h01FF, 16'h0000}) begin
      bad++; $display("FAIL flush_state got v=%b id=%0d d=%h cnt=%h exp 0/0/01ff/0000",
                      out_valid, out_id, out_data, done_cnt);
    end
    flush = 1'b0;
    #1;
    total++;
    if (in_ready !== 4'b1000) begin
      bad++; $display("FAIL flush_ptr_kept got=%b exp=%b", in_ready, 4'b1000);
    end
  endtask

  task automatic test_wrap();
    in_valid = 4'hF; out_ready = 1'b1;
    repeat (65536) cyc();
    total++;
    if (done_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_full got=%h exp=ffff", done_cnt);
    end
    cyc();
    total++;
    if (done_cnt !== 16'h0000) begin
      bad++; $display("FAIL wrap_zero got=%h exp=0000", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 4'hF; out_ready = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0000) begin
      bad++; $display("FAIL rstmid_in_ready got=%b exp=%b", in_ready, 4'b0000);
    end
    cyc();
    total++;
    if ({out_valid, out_id, out_data, done_cnt} !== {1'b0, 2'd0, 16'h0000, 16'h0000}) begin
      bad++; $display("FAIL rstmid_state got v=%b id=%0d d=%h cnt=%h exp 0/0/0000/0000",
                      out_valid, out_id, out_data, done_cnt);
    end
    rst = 1'b0; in_valid = 4'b1110;
    #1;
    total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL rstmid_lowest got=%b exp=%b", in_ready, 4'b0010);
    end
    cyc();
    total++;
    if ({out_valid, out_id, out_data} !== {1'b1, 2'd1, 16'h02FF}) begin
      bad++; $display("FAIL rstmid_first_out got v=%b id=%0d d=%h exp 1/1/02ff", out_valid, out_id, out_data);
    end
  endtask

  initial begin
    in_data = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    test_reset();
    test_round_robin();
    test_backpressure();
    test_rr_pointer();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
